// File: rtl/mesi_coherence_monitor.sv
// rtl/mesi_coherence_monitor.sv - MESI shadow-state monitor snooping acknowledged main-bus transactions
module mesi_coherence_monitor #(
    parameter int NUM_PORTS        = 4,
    parameter int PORT_ID_WIDTH    = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int TABLE_DEPTH      = 8,
    parameter int TABLE_DEPTH_LOG2 = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     mbus_addr_i,
    input  logic [NUM_PORTS-1:0]                mbus_ack_i,
    input  logic                                clear_i,
    output logic                                err_o,
    output logic [5:0]                          err_vec_o,
    output logic [PORT_ID_WIDTH-1:0]            err_port_o,
    output logic [ADDR_WIDTH-1:0]               err_addr_o,
    output logic [TABLE_DEPTH_LOG2:0]           entries_used_o,
    output logic [15:0]                         txn_count_o
);

    localparam int W     = MBUS_CMD_WIDTH;
    localparam int SW    = 2 * NUM_PORTS;
    localparam int CNT_W = TABLE_DEPTH_LOG2 + 1;

    localparam logic [W-1:0] CMD_NOP = W'(0);
    localparam logic [W-1:0] CMD_WR  = W'(1);
    localparam logic [W-1:0] CMD_RD  = W'(2);
    localparam logic [W-1:0] CMD_WRB = W'(3);
    localparam logic [W-1:0] CMD_RDB = W'(4);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    localparam int ERR_WR    = 0;
    localparam int ERR_RD    = 1;
    localparam int ERR_REDUN = 2;
    localparam int ERR_OVF   = 3;
    localparam int ERR_SIMUL = 4;
    localparam int ERR_CMD   = 5;

    // S1 capture registers
    logic                     s1_valid_q, s1_valid_d;
    logic [PORT_ID_WIDTH-1:0] s1_port_q, s1_port_d;
    logic [W-1:0]             s1_cmd_q, s1_cmd_d;
    logic [ADDR_WIDTH-1:0]    s1_addr_q, s1_addr_d;
    logic                     s1_multi_q, s1_multi_d;

    // Shadow table
    logic [TABLE_DEPTH-1:0]   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]    tag_q   [TABLE_DEPTH];
    logic [ADDR_WIDTH-1:0]    tag_d   [TABLE_DEPTH];
    logic [SW-1:0]            state_q [TABLE_DEPTH];
    logic [SW-1:0]            state_d [TABLE_DEPTH];

    logic [5:0]               err_vec_q, err_vec_d;
    logic [PORT_ID_WIDTH-1:0] err_port_q, err_port_d;
    logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
    logic [15:0]              txn_count_q, txn_count_d;

    logic                        hit, free_found;
    logic [TABLE_DEPTH_LOG2-1:0] hit_idx, free_idx;
    logic [SW-1:0]               cur_state, new_state;
    logic [1:0]                  req_st;
    logic                        others_valid;
    logic                        legal;
    logic [5:0]                  rule_err, txn_err;
    logic [CNT_W-1:0]            entries_used;

    // Lowest-index non-NOP ack wins; any further non-NOP ack flags a simultaneous ack
    always_comb begin
        s1_valid_d = 1'b0;
        s1_port_d  = '0;
        s1_cmd_d   = '0;
        s1_addr_d  = '0;
        s1_multi_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (mbus_ack_i[p] && (mbus_cmd_i[p*W +: W] != CMD_NOP)) begin
                if (s1_valid_d) begin
                    s1_multi_d = 1'b1;
                end else begin
                    s1_valid_d = 1'b1;
                    s1_port_d  = PORT_ID_WIDTH'(p);
                    s1_cmd_d   = mbus_cmd_i[p*W +: W];
                    s1_addr_d  = mbus_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
        if (clear_i) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = 0; e < TABLE_DEPTH; e++) begin
            if (valid_q[e] && (tag_q[e] == s1_addr_q) && !hit) begin
                hit     = 1'b1;
                hit_idx = TABLE_DEPTH_LOG2'(e);
            end
            if (!valid_q[e] && !free_found) begin
                free_found = 1'b1;
                free_idx   = TABLE_DEPTH_LOG2'(e);
            end
        end
        cur_state = hit ? state_q[hit_idx] : '0;
    end

    // MESI transition rules for the requester against the looked-up state vector
    always_comb begin
        new_state    = cur_state;
        rule_err     = '0;
        legal        = 1'b1;
        others_valid = 1'b0;
        req_st       = ST_I;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PORT_ID_WIDTH'(p) == s1_port_q) begin
                req_st = cur_state[2*p +: 2];
            end
        end
        case (s1_cmd_q)
            CMD_RDB: begin
                if (req_st != ST_I) begin
                    rule_err[ERR_REDUN] = 1'b1;
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (PORT_ID_WIDTH'(p) != s1_port_q) begin
                        if (cur_state[2*p+1]) begin
                            new_state[2*p +: 2] = ST_S;
                        end
                        if (new_state[2*p +: 2] != ST_I) begin
                            others_valid = 1'b1;
                        end
                    end
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (PORT_ID_WIDTH'(p) == s1_port_q) begin
                        new_state[2*p +: 2] = others_valid ? ST_S : ST_E;
                    end
                end
            end
            CMD_WRB: begin
                if (req_st == ST_M || req_st == ST_E) begin
                    rule_err[ERR_REDUN] = 1'b1;
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    new_state[2*p +: 2] = (PORT_ID_WIDTH'(p) == s1_port_q) ? ST_M : ST_I;
                end
            end
            CMD_WR: begin
                if (req_st == ST_M || req_st == ST_E) begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (PORT_ID_WIDTH'(p) == s1_port_q) begin
                            new_state[2*p +: 2] = ST_M;
                        end
                    end
                end else begin
                    rule_err[ERR_WR] = 1'b1;
                end
            end
            CMD_RD: begin
                if (req_st == ST_I) begin
                    rule_err[ERR_RD] = 1'b1;
                end
            end
            default: begin
                rule_err[ERR_CMD] = 1'b1;
                legal             = 1'b0;
            end
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        state_d     = state_q;
        err_vec_d   = err_vec_q;
        err_port_d  = err_port_q;
        err_addr_d  = err_addr_q;
        txn_count_d = txn_count_q;
        txn_err     = '0;
        if (s1_valid_q) begin
            if (txn_count_q != 16'hFFFF) begin
                txn_count_d = txn_count_q + 16'd1;
            end
            txn_err[ERR_SIMUL] = s1_multi_q;
            if (!hit && !free_found) begin
                txn_err[ERR_OVF] = 1'b1;
            end else begin
                txn_err = txn_err | rule_err;
                if (legal) begin
                    if (hit) begin
                        if (new_state == '0) begin
                            valid_d[hit_idx] = 1'b0;
                        end else begin
                            state_d[hit_idx] = new_state;
                        end
                    end else if (new_state != '0) begin
                        valid_d[free_idx] = 1'b1;
                        tag_d[free_idx]   = s1_addr_q;
                        state_d[free_idx] = new_state;
                    end
                end
            end
            err_vec_d = err_vec_q | txn_err;
            if ((err_vec_q == '0) && (txn_err != '0)) begin
                err_port_d = s1_port_q;
                err_addr_d = s1_addr_q;
            end
        end
        if (clear_i) begin
            valid_d     = '0;
            err_vec_d   = '0;
            err_port_d  = '0;
            err_addr_d  = '0;
            txn_count_d = '0;
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                tag_d[e]   = '0;
                state_d[e] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_port_q   <= '0;
            s1_cmd_q    <= '0;
            s1_addr_q   <= '0;
            s1_multi_q  <= 1'b0;
            valid_q     <= '0;
            err_vec_q   <= '0;
            err_port_q  <= '0;
            err_addr_q  <= '0;
            txn_count_q <= '0;
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                tag_q[e]   <= '0;
                state_q[e] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_port_q   <= s1_port_d;
            s1_cmd_q    <= s1_cmd_d;
            s1_addr_q   <= s1_addr_d;
            s1_multi_q  <= s1_multi_d;
            valid_q     <= valid_d;
            err_vec_q   <= err_vec_d;
            err_port_q  <= err_port_d;
            err_addr_q  <= err_addr_d;
            txn_count_q <= txn_count_d;
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                tag_q[e]   <= tag_d[e];
                state_q[e] <= state_d[e];
            end
        end
    end

    always_comb begin
        entries_used = '0;
        for (int e = 0; e < TABLE_DEPTH; e++) begin
            entries_used = entries_used + CNT_W'(valid_q[e]);
        end
    end

    assign err_o          = |err_vec_q;
    assign err_vec_o      = err_vec_q;
    assign err_port_o     = err_port_q;
    assign err_addr_o     = err_addr_q;
    assign entries_used_o = entries_used;
    assign txn_count_o    = txn_count_q;

endmodule

// File: tb/tb_mesi_coherence_monitor.sv
// tb/tb_mesi_coherence_monitor.sv - directed bench with associative-array MESI reference model
module tb_mesi_coherence_monitor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [11:0]  mbus_cmd_i = '0;
    logic [127:0] mbus_addr_i = '0;
    logic [3:0]   mbus_ack_i = '0;
    logic         clear_i = 1'b0;
    logic         err_o;
    logic [5:0]   err_vec_o;
    logic [1:0]   err_port_o;
    logic [31:0]  err_addr_o;
    logic [3:0]   entries_used_o;
    logic [15:0]  txn_count_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mesi_coherence_monitor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mbus_cmd_i     (mbus_cmd_i),
        .mbus_addr_i    (mbus_addr_i),
        .mbus_ack_i     (mbus_ack_i),
        .clear_i        (clear_i),
        .err_o          (err_o),
        .err_vec_o      (err_vec_o),
        .err_port_o     (err_port_o),
        .err_addr_o     (err_addr_o),
        .entries_used_o (entries_used_o),
        .txn_count_o    (txn_count_o)
    );

    always #5 clk = ~clk;

    // Reference model: line address -> 4 x 2-bit port states (I=0,S=1,E=2,M=3)
    logic [7:0]  m_tab [logic [31:0]];
    logic [5:0]  m_vec = '0;
    int          m_port = 0;
    logic [31:0] m_addr = '0;
    int          m_txn = 0;
    bit          p_v = 1'b0;
    bit          p_simul = 1'b0;
    int          p_port = 0;
    int          p_cmd = 0;
    logic [31:0] p_addr = '0;

    function automatic int gs(input logic [7:0] s, input int p);
        return int'(s[2*p +: 2]);
    endfunction

    task automatic model_step();
        logic [5:0] e;
        logic [7:0] s;
        bit hit;
        bit any;
        int nn;
        if (!rst_n || clear_i) begin
            m_tab.delete();
            m_vec = '0; m_port = 0; m_addr = '0; m_txn = 0; p_v = 1'b0;
            return;
        end
        if (p_v) begin
            e = '0;
            e[4] = p_simul;
            if (m_txn != 65535) m_txn++;
            hit = m_tab.exists(p_addr);
            s = hit ? m_tab[p_addr] : 8'h00;
            if (!hit && m_tab.num() == 8) begin
                e[3] = 1'b1;
            end else if (p_cmd > 4) begin
                e[5] = 1'b1;
            end else begin
                case (p_cmd)
                    4: begin
                        if (gs(s, p_port) != 0) e[2] = 1'b1;
                        any = 1'b0;
                        for (int q = 0; q < 4; q++) begin
                            if (q != p_port) begin
                                if (gs(s, q) >= 2) s[2*q +: 2] = 2'd1;
                                if (gs(s, q) != 0) any = 1'b1;
                            end
                        end
                        s[2*p_port +: 2] = any ? 2'd1 : 2'd2;
                    end
                    3: begin
                        if (gs(s, p_port) >= 2) e[2] = 1'b1;
                        s = 8'h00;
                        s[2*p_port +: 2] = 2'd3;
                    end
                    1: begin
                        if (gs(s, p_port) >= 2) s[2*p_port +: 2] = 2'd3;
                        else e[0] = 1'b1;
                    end
                    default: begin
                        if (gs(s, p_port) == 0) e[1] = 1'b1;
                    end
                endcase
                if (s == 8'h00) begin
                    if (hit) m_tab.delete(p_addr);
                end else begin
                    m_tab[p_addr] = s;
                end
            end
            if (m_vec == '0 && e != '0) begin
                m_port = p_port;
                m_addr = p_addr;
            end
            m_vec = m_vec | e;
        end
        nn = 0;
        for (int p = 0; p < 4; p++) begin
            if (mbus_ack_i[p] && mbus_cmd_i[3*p +: 3] != 3'd0) begin
                if (nn == 0) begin
                    p_port = p;
                    p_cmd  = int'(mbus_cmd_i[3*p +: 3]);
                    p_addr = mbus_addr_i[32*p +: 32];
                end
                nn++;
            end
        end
        p_v = (nn > 0);
        p_simul = (nn > 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model_err_o", 32'(err_o), 32'(m_vec != '0));
            chk("model_err_vec", 32'(err_vec_o), 32'(m_vec));
            chk("model_err_port", 32'(err_port_o), 32'(m_port));
            chk("model_err_addr", err_addr_o, m_addr);
            chk("model_entries", 32'(entries_used_o), 32'(m_tab.num()));
            chk("model_txn", 32'(txn_count_o), 32'(m_txn));
        end
    end

    task automatic idle(input int n);
        mbus_ack_i = '0; mbus_cmd_i = '0; mbus_addr_i = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic txn(input int p, input int cmd, input logic [31:0] addr);
        mbus_ack_i = '0; mbus_cmd_i = '0; mbus_addr_i = '0;
        mbus_ack_i[p] = 1'b1;
        mbus_cmd_i[3*p +: 3] = 3'(cmd);
        mbus_addr_i[32*p +: 32] = addr;
        @(negedge clk);
    endtask

    task automatic do_clear();
        idle(0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic pin(input string tag, input logic [5:0] vec, input int port,
                       input logic [31:0] addr, input int used, input int cnt);
        chk({tag, "_err_o"}, 32'(err_o), 32'(vec != '0));
        chk({tag, "_vec"}, 32'(err_vec_o), 32'(vec));
        chk({tag, "_port"}, 32'(err_port_o), 32'(port));
        chk({tag, "_addr"}, err_addr_o, addr);
        chk({tag, "_used"}, 32'(entries_used_o), 32'(used));
        chk({tag, "_txn"}, 32'(txn_count_o), 32'(cnt));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        pin("reset", 6'b0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;

        // Single RD_BROAD -> E, visible two edges after the ack
        txn(0, 4, 32'h100);
        idle(1);
        pin("rdb_single", 6'b0, 0, 32'h0, 1, 1);

        // Shared then exclusive-write ownership transfer
        do_clear();
        txn(0, 4, 32'h100);
        txn(1, 4, 32'h100);
        txn(2, 3, 32'h100);
        txn(2, 1, 32'h100);
        idle(1);
        pin("share_wrb", 6'b0, 0, 32'h0, 1, 4);
        txn(0, 2, 32'h100);
        txn(1, 2, 32'h100);
        idle(1);
        pin("invalidated_rd", 6'b000010, 0, 32'h100, 1, 6);

        // First-error capture sticks to the first offender
        do_clear();
        txn(3, 1, 32'h200);
        txn(1, 2, 32'h300);
        idle(1);
        pin("illegal_wr_rd", 6'b000011, 3, 32'h200, 0, 2);

        // Simultaneous acks: lowest port kept
        do_clear();
        mbus_ack_i = 4'b0110;
        mbus_cmd_i = {3'd0, 3'd4, 3'd4, 3'd0};
        mbus_addr_i = {32'h0, 32'h20, 32'h10, 32'h0};
        @(negedge clk);
        idle(1);
        pin("simul_ack", 6'b010000, 1, 32'h10, 1, 1);

        // Table overflow on the ninth distinct line, then clear
        do_clear();
        for (int i = 0; i < 9; i++) txn(0, 4, 32'h1000 + 32'(i * 16));
        idle(1);
        pin("overflow", 6'b001000, 0, 32'h1080, 8, 9);
        do_clear();
        pin("after_clear", 6'b0, 0, 32'h0, 0, 0);

        // Redundant broadcast write, then a legal write in M
        txn(0, 4, 32'h40);
        txn(0, 3, 32'h40);
        txn(0, 1, 32'h40);
        idle(1);
        pin("redundant", 6'b000100, 0, 32'h40, 1, 3);

        // Illegal command encoding
        do_clear();
        txn(2, 5, 32'h55);
        idle(1);
        pin("illegal_cmd", 6'b100000, 2, 32'h55, 0, 1);

        // NOP with ack is not a second requester
        do_clear();
        mbus_ack_i = 4'b0011;
        mbus_cmd_i = {3'd0, 3'd0, 3'd4, 3'd0};
        mbus_addr_i = {32'h0, 32'h0, 32'h60, 32'h77};
        @(negedge clk);
        idle(1);
        pin("nop_ack", 6'b0, 0, 32'h0, 1, 1);

        // Clear discards both the S2 transaction and the one captured alongside it
        do_clear();
        txn(0, 4, 32'h80);
        clear_i = 1'b1;
        mbus_ack_i = 4'b0010; mbus_cmd_i = {3'd0, 3'd0, 3'd4, 3'd0};
        mbus_addr_i = {32'h0, 32'h0, 32'h90, 32'h0};
        @(negedge clk);
        clear_i = 1'b0;
        idle(2);
        pin("clear_discard", 6'b0, 0, 32'h0, 0, 0);

        // Reset mid-transaction
        txn(1, 3, 32'hA0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        pin("reset_mid", 6'b0, 0, 32'h0, 0, 0);

        // Back-to-back state reuse: E then write is legal, other port RD after shared
        txn(2, 4, 32'hB0);
        txn(2, 1, 32'hB0);
        txn(3, 4, 32'hB0);
        txn(2, 1, 32'hB0);
        idle(1);
        pin("downgrade_wr", 6'b000001, 2, 32'hB0, 1, 4);

        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
